// File: rtl/imem_prog_loader.sv
// Byte-stream loader for the instruction memory: parses a length/data/checksum frame,
// writes little-endian words to imem and releases the core only after a verified image.
module imem_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StError
  } state_e;

  state_e                r_state;
  logic [15:0]           r_len;
  logic [7:0]            r_sum;
  logic [1:0]            r_byte_cnt;
  logic [15:0]           r_word_cnt;
  logic [23:0]           r_shift;
  logic                  r_in_ready;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic                  r_core_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [7:0]            w_sum;
  logic [15:0]           w_len;
  logic                  w_last_word;

  assign w_accept    = in_valid & r_in_ready;
  assign w_sum       = r_sum + in_data;
  assign w_len       = {in_data, r_len[7:0]};
  assign w_last_word = (r_word_cnt == r_len - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_sum        <= '0;
      r_byte_cnt   <= '0;
      r_word_cnt   <= '0;
      r_shift      <= '0;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        StIdle, StDone, StError: begin
          if (start) begin
            r_state      <= StLenLo;
            r_in_ready   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
            r_sum        <= '0;
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
          end
        end
        StLenLo: begin
          if (w_accept) begin
            r_len[7:0] <= in_data;
            r_sum      <= w_sum;
            r_state    <= StLenHi;
          end
        end
        StLenHi: begin
          if (w_accept) begin
            r_len <= w_len;
            r_sum <= w_sum;
            if (w_len == 16'd0) begin
              r_state <= StCsum;
            end else if ({16'd0, w_len} > MAX_WORDS) begin
              r_state    <= StError;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_accept) begin
            r_sum <= w_sum;
            if (r_byte_cnt == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
              r_imem_wdata <= {in_data, r_shift};
              r_word_cnt   <= r_word_cnt + 16'd1;
              r_byte_cnt   <= 2'd0;
              if (w_last_word) r_state <= StCsum;
            end else begin
              // First byte of a word ends up in bits [7:0] after three shifts.
              r_shift    <= {in_data, r_shift[23:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        StCsum: begin
          if (w_accept) begin
            r_sum      <= w_sum;
            r_in_ready <= 1'b0;
            if (w_sum == 8'd0) begin
              r_state      <= StDone;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= StError;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Table-driven bench for imem_prog_loader: frame vectors plus hand sequences for the
// maximum-size image and reset in the middle of a frame.
module tb_imem_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  imem_prog_loader #(
    .ADDR_WIDTH (8),
    .MAX_WORDS  (256)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [7:0]  b [12];
    bit          thr;
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [6];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  q_addr [$];
  logic [31:0] q_data [$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; idle cycles put garbage on in_data to prove it is ignored.
  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit ok = 1'b0;
    if (thr) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v = vecs[idx];
    q_addr.delete();
    q_data.delete();
    pulse_start();
    for (int i = 0; i < v.nb; i++) send_byte(v.b[i], v.thr);
    chk($sformatf("v%0d_nwrites", idx), q_addr.size(), v.nw);
    if (v.nw > 0 && q_addr.size() > 0) begin
      chk($sformatf("v%0d_addr0", idx), {24'd0, q_addr[0]}, 32'd0);
      chk($sformatf("v%0d_data0", idx), q_data[0], v.d0);
    end
    if (v.nw > 1 && q_addr.size() > 1) begin
      chk($sformatf("v%0d_addr1", idx), {24'd0, q_addr[1]}, 32'd1);
      chk($sformatf("v%0d_data1", idx), q_data[1], v.d1);
    end
    if (v.nw > 0) begin
      chk($sformatf("v%0d_hold_addr", idx), {24'd0, imem_addr}, v.nw - 1);
      chk($sformatf("v%0d_hold_data", idx), imem_wdata, (v.nw > 1) ? v.d1 : v.d0);
    end
    chk($sformatf("v%0d_done", idx), {31'd0, done}, {31'd0, v.exp_done});
    chk($sformatf("v%0d_error", idx), {31'd0, error}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_core_reset", idx), {31'd0, core_reset}, {31'd0, !v.exp_done});
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd0);
    chk($sformatf("v%0d_we_low", idx), {31'd0, imem_we}, 32'd0);
  endtask

  initial begin
    logic [7:0] csum;
    int         bad;

    vecs[0].nb = 7;  vecs[0].thr = 0; vecs[0].nw = 1; vecs[0].d0 = 32'h00A00513;
    vecs[0].b  = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h47, 0, 0, 0, 0, 0};
    vecs[0].d1 = 0;  vecs[0].exp_done = 1; vecs[0].exp_err = 0;
    vecs[1].nb = 3;  vecs[1].thr = 0; vecs[1].nw = 0; vecs[1].d0 = 0;
    vecs[1].b  = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].d1 = 0;  vecs[1].exp_done = 1; vecs[1].exp_err = 0;
    vecs[2].nb = 7;  vecs[2].thr = 0; vecs[2].nw = 1; vecs[2].d0 = 32'h00A00513;
    vecs[2].b  = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h48, 0, 0, 0, 0, 0};
    vecs[2].d1 = 0;  vecs[2].exp_done = 0; vecs[2].exp_err = 1;
    vecs[3]    = vecs[0];
    vecs[4].nb = 2;  vecs[4].thr = 0; vecs[4].nw = 0; vecs[4].d0 = 0;
    vecs[4].b  = '{8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].d1 = 0;  vecs[4].exp_done = 0; vecs[4].exp_err = 1;
    vecs[5].nb = 11; vecs[5].thr = 1; vecs[5].nw = 2; vecs[5].d0 = 32'h00A00513;
    vecs[5].b  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                   8'h93, 8'h05, 8'hB0, 8'h00, 8'hFE, 0};
    vecs[5].d1 = 32'h00B00593; vecs[5].exp_done = 1; vecs[5].exp_err = 0;

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   {31'd0, in_ready},   32'd0);
    chk("rst_we",         {31'd0, imem_we},    32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready",  {31'd0, in_ready},   32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Exactly MAX_WORDS words is legal; word k carries k in its low byte.
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    csum = 8'h01;
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k), 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      csum = csum + 8'(k);
    end
    send_byte(8'h00 - csum, 1'b0);
    chk("max_nwrites", q_addr.size(), 32'd256);
    bad = 0;
    foreach (q_addr[k]) begin
      if (q_addr[k] !== 8'(k) || q_data[k] !== {24'd0, 8'(k)}) bad++;
    end
    chk("max_entries_bad", bad, 32'd0);
    chk("max_done",  {31'd0, done},  32'd1);
    chk("max_error", {31'd0, error}, 32'd0);

    // Reset after three data bytes: everything back to reset values, then a clean reload.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_in_ready",   {31'd0, in_ready},   32'd0);
    chk("mid_we",         {31'd0, imem_we},    32'd0);
    chk("mid_addr",       {24'd0, imem_addr},  32'd0);
    chk("mid_wdata",      imem_wdata,          32'd0);
    chk("mid_core_reset", {31'd0, core_reset}, 32'd1);
    chk("mid_done",       {31'd0, done},       32'd0);
    chk("mid_error",      {31'd0, error},      32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_prog_loader.md
# imem_prog_loader

Byte-stream program loader that fills the instruction memory of the single-cycle RISC-V core and holds the core in reset until a complete, checksum-verified image has been written. It is the input-side counterpart of the result path: the bench or host pushes bytes in through this block, and `result`/`x10_out` are read out of `riscv_top` afterwards. It sits beside `riscv_top`, drives its instruction-memory write port, and drives its active-high `reset`.

## Interface
- `ADDR_WIDTH`, default 8: word-address width of the imem write port.
- `MAX_WORDS`, default 256: largest accepted image, in 32-bit words. Must be ≤ 2^ADDR_WIDTH.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-low reset (sampled on posedge `clk`; 0 = reset).
- `start`  in  1: one-cycle pulse; begins a load from IDLE, DONE or ERROR. Ignored in any other state.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: loader can accept a byte.
- `imem_we`  out  1: one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH: word address of the write.
- `imem_wdata`  out  32: write data.
- `core_reset`  out  1: active-high reset to `riscv_top`.
- `done`  out  1: image loaded and verified.
- `error`  out  1: length or checksum failure.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes, then 1 checksum byte.
- Data words are little-endian. The first byte of each group goes to `wdata[7:0]` and the fourth to `wdata[31:24]`. Word k is written to address k, for k = 0..N-1.
- Checksum: 8-bit running sum (mod 256) over LEN_LO, LEN_HI, all data bytes and the checksum byte. The frame is valid iff this total equals 0x00.
- A byte is accepted on a posedge where `in_valid && in_ready`. No byte is consumed otherwise. `in_valid` may drop between bytes at any time.
- States and transitions:
  - IDLE: `in_ready`=0. `start` → LEN_LO.
  - LEN_LO: accept byte → LEN_HI.
  - LEN_HI: accept byte. If N=0 → CSUM. If N>MAX_WORDS → ERROR. Otherwise → DATA.
  - DATA: accept bytes and assemble words. After the 4th byte of word N-1 → CSUM.
  - CSUM: accept byte. Sum==0 → DONE, else → ERROR.
  - DONE: `done`=1, `core_reset`=0, `in_ready`=0. `start` → LEN_LO.
  - ERROR: `error`=1, `core_reset`=1, `in_ready`=0. Sticky until `start` or `reset`.
- `in_ready` = 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
- `core_reset` = 1 in every state except DONE.
- `start` out of DONE or ERROR clears `done`/`error`, the checksum accumulator, the byte counter and the word counter, and re-asserts `core_reset` from the next cycle.
- Words already written before an ERROR remain in imem; they are not rolled back.

## Timing
- Reset values (cycle after `reset`=0 sampled): state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `error`=0, accumulators 0.
- `reset` has priority over every other input, including mid-frame. A partially received frame is discarded.
- `imem_we` pulses high for exactly one cycle, in the cycle after the posedge that accepted the 4th byte of a word. `imem_addr`/`imem_wdata` are valid in that same cycle and hold until the next write.
- Back-to-back writes are possible every 4 cycles with `in_valid` held high.
- `done`/`core_reset` change in the cycle after the posedge that accepts the checksum byte. `error` behaves the same way, or asserts in the cycle after LEN_HI is accepted when N>MAX_WORDS.
- Byte throughput is 1 per cycle. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- Single word: `start`, then bytes 01 00 13 05 A0 00 47 → one `imem_we` pulse with addr 0, data 0x00A00513. Then `done`=1, `core_reset`=0, `error`=0. The bench releases the core and checks `x10_out`=10 after 3 cycles.
- Empty image: bytes 00 00 00 → no `imem_we`, `done`=1 one cycle after the 3rd byte.
- Bad checksum: bytes 01 00 13 05 A0 00 48 → the word is still written at addr 0, then `error`=1, `done`=0, `core_reset`=1. A following `start` plus a valid frame yields `done`=1.
- Oversize: N bytes 01 01 (257 > 256) → `error`=1 after LEN_HI, `in_ready`=0, no writes.
- Throttled stream: 2-word frame 02 00 [0x00A00513] [0x00B00593] plus the correct checksum, with `in_valid` toggling randomly → addrs 0 and 1, correct data, one pulse each.
- Reset mid-frame: drive `reset`=0 after 3 data bytes → all outputs return to reset values. A subsequent full frame loads correctly from addr 0.
